pipelined_rshift: RTL and testbench

- Fully pipelined logarithmic right shifter: logical or arithmetic shift of a WIDTH-bit operand by a SHW-bit amount.
- Counterpart to the team's left-shift timing experiment; used for fmax and timing studies of the opposite-direction datapath on the board.
- Valid/ready streaming on both ends; one result per clock at full throughput.
- Top byte of the current result is driven to the PMOD header.

---
 rtl/pipelined_rshift.sv | 86 ++++++++
 tb/tb_pipelined_rshift.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_rshift.sv
// Pipelined logarithmic right shifter, logical or arithmetic.
// One shift stage per amount bit, with valid/ready flow control at both ends.
module pipelined_rshift #(
   parameter int WIDTH = 32,
   parameter int SHW   = 5
) (
   input  logic             sys_clk,
   input  logic             ck_rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] v,
   input  logic [SHW-1:0]   d,
   input  logic             arith,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] q,
   output logic [7:0]       ja
);

   logic [SHW-1:0] st_valid;
   logic [SHW-1:0] adv;

   // A stage may load when its consumer moves or it holds a bubble.
   assign adv[SHW-1] = out_ready | ~st_valid[SHW-1];

   for (genvar k = 0; k < SHW - 1; k++) begin : g_adv
      assign adv[k] = adv[k+1] | ~st_valid[k];
   end

   assign in_ready = adv[0];

   for (genvar k = 0; k < SHW; k++) begin : g_stage
      localparam int SH = 1 << k;

      logic [WIDTH-1:0] data;
      logic [SHW-1:0]   amt;
      logic             ar;
      logic             vld;

      logic [WIDTH-1:0] src_data;
      logic [SHW-1:0]   src_amt;
      logic             src_ar;
      logic             src_vld;
      logic [WIDTH-1:0] fill;
      logic [WIDTH-1:0] nxt_data;

      if (k == 0) begin : g_head
         assign src_data = v;
         assign src_amt  = d;
         assign src_ar   = arith;
         assign src_vld  = in_valid & in_ready;
      end else begin : g_body
         assign src_data = g_stage[k-1].data;
         assign src_amt  = g_stage[k-1].amt;
         assign src_ar   = g_stage[k-1].ar;
         assign src_vld  = g_stage[k-1].vld;
      end

      // Incoming MSB is still the original sign at every stage.
      assign fill     = {WIDTH{src_ar & src_data[WIDTH-1]}};
      assign nxt_data = src_amt[k]
                      ? ((src_data >> SH) | (fill << (WIDTH - SH)))
                      : src_data;

      always_ff @(posedge sys_clk or posedge ck_rst) begin
         if (ck_rst) begin
            data <= '0;
            amt  <= '0;
            ar   <= 1'b0;
            vld  <= 1'b0;
         end else if (adv[k]) begin
            data <= nxt_data;
            amt  <= src_amt;
            ar   <= src_ar;
            vld  <= src_vld;
         end
      end

      assign st_valid[k] = vld;
   end

   assign q         = g_stage[SHW-1].data;
   assign out_valid = g_stage[SHW-1].vld;
   assign ja        = q[WIDTH-1 -: 8];

endmodule

// File: tb/tb_pipelined_rshift.sv
// Directed self-checking bench for pipelined_rshift.
// Covers latency, boundaries, streaming, stall and reset flush.
module tb_pipelined_rshift;

   localparam int WIDTH = 32;
   localparam int SHW   = 5;

   logic             sys_clk = 1'b0;
   logic             ck_rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] v;
   logic [SHW-1:0]   d;
   logic             arith;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] q;
   logic [7:0]       ja;

   int checks = 0;
   int errors = 0;

   always #5 sys_clk = ~sys_clk;

   pipelined_rshift #(.WIDTH(WIDTH), .SHW(SHW)) dut (
      .sys_clk  (sys_clk),
      .ck_rst   (ck_rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .v        (v),
      .d        (d),
      .arith    (arith),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .q        (q),
      .ja       (ja)
   );

   task automatic test_reset();
      ck_rst    = 1'b1;
      in_valid  = 1'b0;
      v         = '0;
      d         = '0;
      arith     = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(negedge sys_clk);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_out_valid: got %b expected 0", out_valid);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready: got %b expected 1", in_ready);
      end
      checks++;
      if (q !== 32'h0 || ja !== 8'h0) begin
         errors++;
         $display("FAIL reset_q: got q=%h ja=%h expected 0/0", q, ja);
      end
      ck_rst = 1'b0;
      @(negedge sys_clk);
   endtask

   task automatic test_single();
      logic [31:0] tv [7];
      logic [4:0]  td [7];
      logic        ta [7];
      logic [31:0] te [7];
      logic [31:0] e;
      tv = '{32'h1234_5678, 32'h8000_0000, 32'h8000_0000, 32'hF000_0000,
             32'hF000_0000, 32'h7FFF_FFFF, 32'h4000_0000};
      td = '{5'd0, 5'd31, 5'd31, 5'd4, 5'd4, 5'd31, 5'd8};
      ta = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      te = '{32'h1234_5678, 32'h0000_0001, 32'hFFFF_FFFF, 32'hFF00_0000,
             32'h0F00_0000, 32'h0000_0000, 32'h0040_0000};
      for (int i = 0; i < 7; i++) begin
         @(negedge sys_clk);
         in_valid  = 1'b1;
         v         = tv[i];
         d         = td[i];
         arith     = ta[i];
         out_ready = 1'b1;
         #1;
         checks++;
         if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_in_ready[%0d]: got %b expected 1", i, in_ready);
         end
         @(negedge sys_clk);
         in_valid = 1'b0;
         repeat (3) @(negedge sys_clk);
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_early[%0d]: out_valid %b expected 0", i, out_valid);
         end
         @(negedge sys_clk);
         e = te[i];
         checks++;
         if (out_valid !== 1'b1 || q !== e || ja !== e[31:24]) begin
            errors++;
            $display("FAIL single_q[%0d]: got v=%b q=%h ja=%h expected 1 %h %h",
                     i, out_valid, q, ja, e, e[31:24]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int          sent;
      int          got;
      int          first;
      logic [31:0] e;
      sent  = 0;
      got   = 0;
      first = -1;
      out_ready = 1'b1;
      arith     = 1'b0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         @(negedge sys_clk);
         in_valid = (sent < 8);
         v        = 32'h8000_0000;
         d        = 5'(sent);
         #1;
         if (in_valid && in_ready) sent++;
         if (out_valid) begin
            if (first < 0) first = cyc;
            e = 32'h8000_0000 >> got;
            checks++;
            if (got >= 8 || q !== e || cyc !== first + got) begin
               errors++;
               $display("FAIL b2b[%0d]: got q=%h cyc=%0d expected %h cyc=%0d",
                        got, q, cyc, e, first + got);
            end
            got++;
         end
      end
      in_valid = 1'b0;
      checks++;
      if (first !== SHW) begin
         errors++;
         $display("FAIL b2b_latency: got %0d expected %0d", first, SHW);
      end
      checks++;
      if (got !== 8) begin
         errors++;
         $display("FAIL b2b_count: got %0d expected 8", got);
      end
   endtask

   task automatic test_stall();
      logic [31:0] te [8];
      int          sent;
      int          got;
      logic        exp_rdy;
      te = '{32'h8000_0000, 32'hC000_0000, 32'hE000_0000, 32'hF000_0000,
             32'hF800_0000, 32'hFC00_0000, 32'hFE00_0000, 32'hFF00_0000};
      sent  = 0;
      got   = 0;
      arith = 1'b1;
      for (int cyc = 0; cyc < 40; cyc++) begin
         @(negedge sys_clk);
         in_valid  = (sent < 8);
         v         = 32'h8000_0000;
         d         = 5'(sent);
         out_ready = (cyc >= 10);
         #1;
         if (cyc < 10) begin
            exp_rdy = (sent < 5);
            checks++;
            if (in_ready !== exp_rdy) begin
               errors++;
               $display("FAIL stall_in_ready[c%0d]: got %b expected %b",
                        cyc, in_ready, exp_rdy);
            end
            if (out_valid) begin
               checks++;
               if (q !== te[0]) begin
                  errors++;
                  $display("FAIL stall_hold[c%0d]: got %h expected %h",
                           cyc, q, te[0]);
               end
            end
         end
         if (cyc == 10) begin
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
               errors++;
               $display("FAIL stall_full_swap: got rdy=%b vld=%b expected 1 1",
                        in_ready, out_valid);
            end
         end
         if (in_valid && in_ready) sent++;
         if (out_valid && out_ready) begin
            checks++;
            if (got >= 8) begin
               errors++;
               $display("FAIL stall_extra: got q=%h expected no result", q);
            end else if (q !== te[got]) begin
               errors++;
               $display("FAIL stall_q[%0d]: got %h expected %h", got, q, te[got]);
            end
            got++;
         end
      end
      in_valid = 1'b0;
      checks++;
      if (got !== 8) begin
         errors++;
         $display("FAIL stall_count: got %0d expected 8", got);
      end
   endtask

   task automatic test_reset_mid();
      int got;
      got       = 0;
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge sys_clk);
         in_valid = 1'b1;
         v        = 32'hFFFF_0000;
         d        = 5'(i);
         arith    = 1'b1;
      end
      @(negedge sys_clk);
      in_valid = 1'b0;
      ck_rst   = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || q !== 32'h0 || ja !== 8'h0) begin
         errors++;
         $display("FAIL mid_reset: got vld=%b rdy=%b q=%h ja=%h expected 0 1 0 0",
                  out_valid, in_ready, q, ja);
      end
      @(negedge sys_clk);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_hold: got %b expected 0", out_valid);
      end
      ck_rst    = 1'b0;
      out_ready = 1'b1;
      @(negedge sys_clk);
      in_valid = 1'b1;
      v        = 32'h0000_0100;
      d        = 5'd8;
      arith    = 1'b0;
      @(negedge sys_clk);
      in_valid = 1'b0;
      repeat (15) begin
         @(negedge sys_clk);
         if (out_valid) begin
            checks++;
            if (got != 0 || q !== 32'h0000_0001) begin
               errors++;
               $display("FAIL mid_result[%0d]: got %h expected 00000001 once", got, q);
            end
            got++;
         end
      end
      checks++;
      if (got !== 1) begin
         errors++;
         $display("FAIL mid_count: got %0d expected 1", got);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_stall();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
